psum_requant_packer: RTL and testbench

//  Downstream neighbour of the PE array column output. Consumes the 32-bit signed opsum stream
//  (valid/ready), requantizes each psum to int8 (round, shift, optional ReLU, saturate) and
//  re-encodes it to the uint8 ifmap format (xor 8'h80). Packs 4 bytes per 32-bit ofmap word for
//  GLB write-back; byte lane 0 = first psum, at bits [7:0].

---
 rtl/ppu_pkg.sv | 10 +
 rtl/ppu_quant.sv | 34 +++
 rtl/psum_requant_packer.sv | 129 ++++++++++++
 tb/tb_psum_requant_packer.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/ppu_pkg.sv
// ppu_pkg: shared FSM state type and int8/uint8 requantization constants for the psum packer.
//   state_t      : packer FSM states IDLE / RUN / DONE
//   INT8_MAX/MIN : saturation bounds of the signed int8 result
//   UINT8_OFFSET : xor mask that re-encodes int8 into the uint8 ifmap format
package ppu_pkg;
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   localparam int         INT8_MAX     = 127;
   localparam int         INT8_MIN     = -128;
   localparam logic [7:0] UINT8_OFFSET = 8'h80;
endpackage

// File: rtl/ppu_quant.sv
// ppu_quant: combinational requantizer, signed psum -> rounded, shifted, saturated uint8 byte.
//   i_psum  : signed partial sum (PSUM_BITS)
//   i_shift : right-shift amount 0..31, rounds half up when non-zero
//   i_relu  : clamp negatives to 0 (port exists only when PPU_RELU_EN is defined)
//   o_byte  : saturated int8 result xor 8'h80
// Build option: PPU_RELU_EN enables the ReLU clamp; without it negatives saturate to -128 only.
module ppu_quant
   import ppu_pkg::*;
#(
   parameter int PSUM_BITS = 32
) (
   input  logic signed [PSUM_BITS-1:0] i_psum,
   input  logic        [4:0]           i_shift,
`ifdef PPU_RELU_EN
   input  logic                        i_relu,
`endif
   output logic        [7:0]           o_byte
);
   localparam logic signed [PSUM_BITS:0] L_MAX = (PSUM_BITS+1)'(INT8_MAX);
   localparam logic signed [PSUM_BITS:0] L_MIN = (PSUM_BITS+1)'(INT8_MIN);
   // One extra bit keeps psum + rounding constant from overflowing.
   logic signed [PSUM_BITS:0] w_rnd, w_sum, w_shr, w_act;
   always_comb begin
      w_rnd = (i_shift == 5'd0) ? '0 : ((PSUM_BITS+1)'(1) << (i_shift - 5'd1));
      w_sum = {i_psum[PSUM_BITS-1], i_psum} + w_rnd;
      w_shr = w_sum >>> i_shift;
`ifdef PPU_RELU_EN
      w_act = (i_relu && w_shr < 0) ? '0 : w_shr;
`else
      w_act = w_shr;
`endif
      o_byte = (w_act > L_MAX ? 8'(INT8_MAX) : w_act < L_MIN ? 8'(INT8_MIN) : w_act[7:0]) ^ UINT8_OFFSET;
   end
endmodule

// File: rtl/psum_requant_packer.sv
// psum_requant_packer: requantizes a 32-bit signed opsum stream to uint8 and packs 4 bytes per ofmap word.
//   clk, rst          : clock; asynchronous active-low reset
//   start, cfg_*      : job start pulse with shift, relu and element count (latched only when idle)
//   busy, done        : job in progress; one-cycle completion pulse
//   opsum*            : valid/ready input stream of signed psums
//   ofmap*            : valid/ready output of packed words, lane 0 = first psum at [7:0], strb = filled lanes
// Build option: PPU_RELU_EN honours cfg_relu; otherwise cfg_relu is ignored.
module psum_requant_packer
   import ppu_pkg::*;
#(
   parameter int PSUM_BITS = 32,
   parameter int DATA_BITS = 32,
   parameter int LANES     = 4,
   parameter int LEN_BITS  = 16
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        start,
   input  logic        [4:0]           cfg_shift,
   input  logic                        cfg_relu,
   input  logic        [LEN_BITS-1:0]  cfg_len,
   output logic                        busy,
   output logic                        done,
   input  logic signed [PSUM_BITS-1:0] opsum,
   input  logic                        opsum_valid,
   output logic                        opsum_ready,
   output logic        [DATA_BITS-1:0] ofmap,
   output logic        [LANES-1:0]     ofmap_strb,
   output logic                        ofmap_valid,
   input  logic                        ofmap_ready
);
   localparam int LW = $clog2(LANES + 1);
   state_t               r_state;
   logic [4:0]           r_shift;
   logic [LEN_BITS-1:0]  r_len, r_elem_cnt;
   logic [LW-1:0]        r_lane_cnt;
   logic [DATA_BITS-1:0] r_pack, r_ofmap;
   logic [LANES-1:0]     r_strb;
   logic                 r_ofmap_valid, r_flush;
   logic [7:0]           w_byte;
   logic [DATA_BITS-1:0] w_word;
   logic [LW-1:0]        w_nlanes;
   logic [LANES:0]       w_mask;
   logic                 w_out_free, w_acc, w_fill, w_pend, w_emit, w_last_out;
`ifdef PPU_RELU_EN
   logic                 r_relu;
`endif

   ppu_quant #(.PSUM_BITS(PSUM_BITS)) u_quant (
      .i_psum  (opsum),
      .i_shift (r_shift),
`ifdef PPU_RELU_EN
      .i_relu  (r_relu),
`endif
      .o_byte  (w_byte)
   );

   always_comb begin
      w_out_free  = !r_ofmap_valid || ofmap_ready;
      opsum_ready = r_state == RUN && r_elem_cnt < r_len && (r_lane_cnt < LW'(LANES - 1) || w_out_free);
      w_acc       = opsum_valid && opsum_ready;
      w_nlanes    = r_lane_cnt + LW'(w_acc);
      w_word      = r_pack | (w_acc ? DATA_BITS'(w_byte) << (8 * r_lane_cnt) : '0);
      w_mask      = ((LANES+1)'(1) << w_nlanes) - (LANES+1)'(1);
      w_fill      = w_acc && (w_nlanes == LW'(LANES) || r_elem_cnt + LEN_BITS'(1) == r_len);
      // A trailing partial word waits in the pack register (r_flush) while the output slot is busy.
      w_pend      = w_fill || r_flush;
      w_emit      = w_pend && w_out_free;
      w_last_out  = r_elem_cnt == r_len && !r_flush && r_ofmap_valid && ofmap_ready;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state       <= IDLE;
         r_shift       <= '0;
         r_len         <= '0;
         r_elem_cnt    <= '0;
         r_lane_cnt    <= '0;
         r_pack        <= '0;
         r_ofmap       <= '0;
         r_strb        <= '0;
         r_ofmap_valid <= 1'b0;
         r_flush       <= 1'b0;
`ifdef PPU_RELU_EN
         r_relu        <= 1'b0;
`endif
      end else begin
         if (r_state == IDLE && start) begin
            r_shift    <= cfg_shift;
            r_len      <= cfg_len;
            r_elem_cnt <= '0;
`ifdef PPU_RELU_EN
            r_relu     <= cfg_relu;
`endif
            r_state    <= (cfg_len == '0) ? DONE : RUN;
         end else if (r_state == RUN && w_last_out) begin
            r_state <= DONE;
         end else if (r_state == DONE) begin
            r_state <= IDLE;
         end
         if (w_acc) r_elem_cnt <= r_elem_cnt + LEN_BITS'(1);
         r_flush <= w_pend && !w_emit;
         if (w_emit) begin
            r_ofmap       <= w_word;
            r_strb        <= w_mask[LANES-1:0];
            r_ofmap_valid <= 1'b1;
            r_pack        <= '0;
            r_lane_cnt    <= '0;
         end else begin
            if (w_acc) begin
               r_pack     <= w_word;
               r_lane_cnt <= w_nlanes;
            end
            if (ofmap_ready) r_ofmap_valid <= 1'b0;
         end
      end
   end

`ifndef PPU_RELU_EN
   logic w_relu_unused;
   assign w_relu_unused = cfg_relu;
`endif

   assign busy        = r_state != IDLE;
   assign done        = r_state == DONE;
   assign ofmap       = r_ofmap;
   assign ofmap_strb  = r_strb;
   assign ofmap_valid = r_ofmap_valid;
endmodule

// File: tb/tb_psum_requant_packer.sv
// tb_psum_requant_packer: directed table, corner sequences and randomized jobs checked against a behavioural model.
module tb_psum_requant_packer;
   logic               clk, rst, start, cfg_relu, busy, done;
   logic        [4:0]  cfg_shift;
   logic        [15:0] cfg_len;
   logic signed [31:0] opsum;
   logic               opsum_valid, opsum_ready, ofmap_valid, ofmap_ready;
   logic        [31:0] ofmap;
   logic        [3:0]  ofmap_strb;

   int          total = 0, bad = 0, done_cnt = 0, rdy_pct = 100;
   int          ps_q[$];
   logic [35:0] got[$];
   logic [35:0] held;
   bit          hold = 0;

   psum_requant_packer dut (
      .clk(clk), .rst(rst), .start(start), .cfg_shift(cfg_shift), .cfg_relu(cfg_relu),
      .cfg_len(cfg_len), .busy(busy), .done(done), .opsum(opsum), .opsum_valid(opsum_valid),
      .opsum_ready(opsum_ready), .ofmap(ofmap), .ofmap_strb(ofmap_strb),
      .ofmap_valid(ofmap_valid), .ofmap_ready(ofmap_ready)
   );

   initial clk = 0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   // Reference requantizer: round half up, arithmetic shift, optional ReLU, clamp, offset.
   function automatic logic [7:0] qmodel(input int p, input int sh, input bit rl);
      longint v = p;
      if (sh > 0) v = (v + (longint'(1) << (sh - 1))) >>> sh;
`ifdef PPU_RELU_EN
      if (rl && v < 0) v = 0;
`else
      if (rl) v = v;
`endif
      if (v > 127) v = 127;
      if (v < -128) v = -128;
      return 8'(v) ^ 8'h80;
   endfunction

   always begin
      @(posedge clk);
      #1 ofmap_ready = $urandom_range(99) < rdy_pct;
   end

   always @(negedge clk) begin
      if (!rst) hold = 0;
      else begin
         if (hold) chk("ofmap_hold", {27'd0, ofmap_valid, ofmap_strb, ofmap}, {27'd0, 1'b1, held});
         if (ofmap_valid && ofmap_ready) got.push_back({ofmap_strb, ofmap});
         if (done) done_cnt++;
         hold = ofmap_valid && !ofmap_ready;
         held = {ofmap_strb, ofmap};
      end
   end

   task automatic run_job(input int sh, input bit rl, input int vp, input bit spur, input string nm);
      int n = ps_q.size();
      int idx = 0, cyc = 0;
      bit acc;
      logic [35:0] exp_q[$];
      logic [31:0] w;
      logic [3:0]  s;
      for (int i = 0; i < n; i += 4) begin
         w = '0; s = '0;
         for (int l = 0; l < 4; l++)
            if (i + l < n) begin
               w[8*l +: 8] = qmodel(ps_q[i+l], sh, rl);
               s[l] = 1'b1;
            end
         exp_q.push_back({s, w});
      end
      got.delete();
      done_cnt = 0;
      @(posedge clk); #1;
      start = 1; cfg_shift = 5'(sh); cfg_relu = rl; cfg_len = 16'(n);
      @(posedge clk); #1;
      start = 0;
      while (idx < n && cyc < 2000) begin
         start = spur && cyc == 2;
         if (start) begin cfg_shift = 5'($urandom); cfg_len = 16'd1; cfg_relu = ~rl; end
         opsum = ps_q[idx];
         opsum_valid = $urandom_range(99) < vp;
         @(negedge clk);
         acc = opsum_valid && opsum_ready;
         @(posedge clk); #1;
         if (acc) idx++;
         cyc++;
      end
      start = 0; opsum_valid = 0;
      if (cyc >= 2000) begin
         total++; bad++;
         $display("FAIL %s feed_timeout accepted=%0d required=%0d", nm, idx, n);
      end
      for (int c = 0; c < 400 && done_cnt == 0; c++) @(negedge clk);
      repeat (3) @(negedge clk);
      chk({nm, " done_pulses"}, 64'(done_cnt), 64'd1);
      chk({nm, " word_count"}, 64'(got.size()), 64'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < got.size(); i++)
         chk($sformatf("%s word%0d", nm, i), 64'(got[i]), 64'(exp_q[i]));
   endtask

   typedef struct {
      int         p;
      int         sh;
      bit         rl;
      logic [7:0] exp;
   } vec_t;
   vec_t tbl[12];

   initial begin
      rst = 0; start = 0; cfg_shift = 0; cfg_relu = 0; cfg_len = 0;
      opsum = 0; opsum_valid = 0; ofmap_ready = 0;
      tbl[0]  = '{6, 2, 0, 8'h82};
      tbl[1]  = '{-6, 2, 0, 8'h7F};
      tbl[2]  = '{2, 2, 0, 8'h81};
      tbl[3]  = '{1000, 0, 0, 8'hFF};
      tbl[4]  = '{-1000, 0, 0, 8'h00};
      tbl[5]  = '{0, 0, 0, 8'h80};
`ifdef PPU_RELU_EN
      tbl[6]  = '{-5, 0, 1, 8'h80};
`else
      tbl[6]  = '{-5, 0, 1, 8'h7B};
`endif
      tbl[7]  = '{32'h7FFFFFFF, 31, 0, 8'h81};
      tbl[8]  = '{32'h80000000, 31, 0, 8'h7F};
      tbl[9]  = '{255, 1, 0, 8'hFF};
      tbl[10] = '{-257, 1, 0, 8'h00};
      tbl[11] = '{3, 1, 0, 8'h82};

      repeat (3) @(posedge clk);
      #1;
      chk("reset busy", 64'(busy), 0);
      chk("reset done", 64'(done), 0);
      chk("reset opsum_ready", 64'(opsum_ready), 0);
      chk("reset ofmap_valid", 64'(ofmap_valid), 0);
      chk("reset ofmap", 64'(ofmap), 0);
      chk("reset strb", 64'(ofmap_strb), 0);
      rst = 1;

      rdy_pct = 100;
      for (int i = 0; i < 12; i++) begin
         ps_q = '{tbl[i].p};
         run_job(tbl[i].sh, tbl[i].rl, 100, 0, $sformatf("tbl%0d", i));
         if (got.size() > 0) chk($sformatf("tbl%0d byte", i), 64'(got[0]), 64'({4'h1, 24'd0, tbl[i].exp}));
      end

      ps_q = '{1, 2, 3, 4};
      run_job(0, 0, 100, 0, "seq4");
      if (got.size() > 0) chk("seq4 const", 64'(got[0]), 64'({4'hF, 32'h84838281}));

      ps_q = '{1, 1, 1, 1, 1};
      run_job(0, 0, 100, 0, "len5");
      if (got.size() == 2) begin
         chk("len5 w0", 64'(got[0]), 64'({4'hF, 32'h81818181}));
         chk("len5 w1", 64'(got[1]), 64'({4'h1, 32'h00000081}));
      end

      ps_q = '{1, 2, 3, 4, 5, 6, 7, 8};
      rdy_pct = 0;
      fork
         run_job(0, 0, 100, 0, "stall");
         begin
            for (int c = 0; c < 50 && !ofmap_valid; c++) @(negedge clk);
            repeat (10) @(negedge clk);
            chk("stall opsum_ready", 64'(opsum_ready), 0);
            chk("stall ofmap", 64'({ofmap_valid, ofmap_strb, ofmap}), 64'({1'b1, 4'hF, 32'h84838281}));
            rdy_pct = 100;
         end
      join

      @(posedge clk); #1;
      start = 1; cfg_len = 0;
      @(posedge clk); #1;
      start = 0;
      @(negedge clk);
      chk("len0 done", 64'(done), 1);
      chk("len0 ofmap_valid", 64'(ofmap_valid), 0);
      @(negedge clk);
      chk("len0 done_after", 64'({done, ofmap_valid}), 0);

      @(posedge clk); #1;
      start = 1; cfg_len = 16'd8; cfg_shift = 0;
      @(posedge clk); #1;
      start = 0; opsum = 9; opsum_valid = 1;
      repeat (6) @(posedge clk);
      #1;
      rst = 0; opsum_valid = 0;
      #1;
      chk("midrst outputs", 64'({busy, done, opsum_ready, ofmap_valid, ofmap_strb, ofmap}), 0);
      @(posedge clk); #1;
      rst = 1;

      for (int j = 0; j < 40; j++) begin
         int n, sh, k;
         n = $urandom_range(1, 13);
         sh = $urandom_range(1) ? $urandom_range(0, 4) : $urandom_range(0, 31);
         ps_q.delete();
         for (int i = 0; i < n; i++) begin
            k = $urandom_range(2);
            ps_q.push_back(k == 0 ? $urandom_range(600) - 300 : k == 1 ? int'($urandom) : int'($urandom) >>> $urandom_range(31));
         end
         rdy_pct = $urandom_range(30, 100);
         run_job(sh, 1'($urandom), $urandom_range(30, 100), 1'($urandom), $sformatf("rnd%0d", j));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
